// File: rtl/spi_frame_tx.sv
// Serializes one {cmd, addr, data} write request into a 64-bit LSB-first frame framed by cs.
// Define SPI_FRAME_TX_FRAME_CNT_EN to add the 16-bit completed-frame counter output frame_cnt.
module spi_frame_tx #(
  parameter int unsigned TAIL_CYCLES = 1,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_data,
  output logic        cs,
  output logic        miso,
  output logic        busy,
  output logic        frame_done
`ifdef SPI_FRAME_TX_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StShift, StTail, StGap} state_e;

  // The IDLE cycle in which the next accept happens is itself a cs-low cycle, so GAP only
  // has to cover GAP_CYCLES-1 of them; GAP_CYCLES of 0 or 1 returns straight to IDLE.
  localparam bit         UseGap   = (GAP_CYCLES > 1);
  localparam logic [3:0] TailLast = 4'(TAIL_CYCLES - 1);
  localparam logic [3:0] GapLast  = UseGap ? 4'(GAP_CYCLES - 2) : 4'd0;

  state_e      state_q;
  logic [63:0] shreg_q;
  logic [5:0]  bit_cnt_q;
  logic [3:0]  tail_cnt_q;
  logic [3:0]  gap_cnt_q;
  logic [63:0] frame;

  assign frame     = {req_cmd, req_addr, req_data};
  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      tail_cnt_q <= '0;
      gap_cnt_q  <= '0;
      cs         <= 1'b0;
      miso       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            // Bit 0 goes out immediately; the register keeps the remaining 63 bits.
            shreg_q   <= {1'b0, frame[63:1]};
            miso      <= frame[0];
            cs        <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= StShift;
          end
        end
        StShift: begin
          if (bit_cnt_q == 6'd63) begin
            miso       <= 1'b0;
            tail_cnt_q <= '0;
            state_q    <= StTail;
          end else begin
            miso      <= shreg_q[0];
            shreg_q   <= {1'b0, shreg_q[63:1]};
            bit_cnt_q <= bit_cnt_q + 6'd1;
          end
        end
        StTail: begin
          if (tail_cnt_q == TailLast) begin
            cs         <= 1'b0;
            frame_done <= 1'b1;
            gap_cnt_q  <= '0;
            state_q    <= UseGap ? StGap : StIdle;
          end else begin
            tail_cnt_q <= tail_cnt_q + 4'd1;
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end
      endcase
    end
  end

`ifdef SPI_FRAME_TX_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_done) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_frame_tx.sv
// Self-checking bench for spi_frame_tx: default instance plus a TAIL_CYCLES=3 / GAP_CYCLES=0 one.
// Waveforms are sampled per cycle into queues and judged against frame-level expectations.
module tb_spi_frame_tx;

  // Expected timing, in samples taken after accept edge E0 (index i = state after Ei).
  localparam int CsLenDef  = 65;  // cs high after E0..E64
  localparam int FdIdxDef  = 65;  // cs falls, frame_done pulses
  localparam int RdyIdxDef = 66;  // accept possible at E67
  localparam int CsLenT3   = 67;
  localparam int FdIdxT3   = 67;
  localparam int RdyIdxT3  = 67;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_valid2;
  logic [7:0]  req_cmd;
  logic [23:0] req_addr;
  logic [31:0] req_data;
  logic        req_ready, cs, miso, busy, frame_done;
  logic        req_ready2, cs2, miso2, busy2, frame_done2;
`ifdef SPI_FRAME_TX_FRAME_CNT_EN
  logic [15:0] frame_cnt, frame_cnt2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic cs_s[$];
  logic miso_s[$];
  logic fd_s[$];
  logic rdy_s[$];
  logic busy_s[$];

  always #5 clk = ~clk;

  spi_frame_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .cs         (cs),
    .miso       (miso),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef SPI_FRAME_TX_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  spi_frame_tx #(
    .TAIL_CYCLES (3),
    .GAP_CYCLES  (0)
  ) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid2),
    .req_ready  (req_ready2),
    .req_cmd    (req_cmd),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .cs         (cs2),
    .miso       (miso2),
    .busy       (busy2),
    .frame_done (frame_done2)
`ifdef SPI_FRAME_TX_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt2)
`endif
  );

  task automatic clear_samples();
    cs_s.delete();
    miso_s.delete();
    fd_s.delete();
    rdy_s.delete();
    busy_s.delete();
  endtask

  task automatic sample_one(input bit sel);
    @(negedge clk);
    cs_s.push_back(sel ? cs2 : cs);
    miso_s.push_back(sel ? miso2 : miso);
    fd_s.push_back(sel ? frame_done2 : frame_done);
    rdy_s.push_back(sel ? req_ready2 : req_ready);
    busy_s.push_back(sel ? busy2 : busy);
  endtask

  // Single-cycle request: valid drops right after the accept edge.
  task automatic capture(input int n, input bit sel);
    clear_samples();
    for (int i = 0; i < n; i++) begin
      sample_one(sel);
      if (i == 0) begin
        req_valid  = 1'b0;
        req_valid2 = 1'b0;
      end
    end
  endtask

  function automatic logic [63:0] frame_at(input int start);
    logic [63:0] f;
    f = 'x;
    for (int i = 0; i < 64; i++) begin
      if (start + i < miso_s.size()) f[i] = miso_s[start + i];
    end
    return f;
  endfunction

  function automatic int cs_run(input int start, input logic val);
    int n;
    n = 0;
    for (int i = start; i < cs_s.size(); i++) begin
      if (cs_s[i] !== val) break;
      n++;
    end
    return n;
  endfunction

  function automatic int fd_count();
    int n;
    n = 0;
    foreach (fd_s[i]) if (fd_s[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int fd_first();
    foreach (fd_s[i]) if (fd_s[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int first_ready(input int start);
    for (int i = start; i < rdy_s.size(); i++) if (rdy_s[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int busy_run(input int start);
    int n;
    n = 0;
    for (int i = start; i < busy_s.size(); i++) begin
      if (busy_s[i] !== 1'b1) break;
      n++;
    end
    return n;
  endfunction

  task automatic test_reset();
    req_valid  = 1'b0;
    req_valid2 = 1'b0;
    req_cmd    = '0;
    req_addr   = '0;
    req_data   = '0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    #2;
    n_tests++;
    if ({cs, miso, busy, frame_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: cs/miso/busy/done=%b required 0000",
               {cs, miso, busy, frame_done});
    end
    n_tests++;
    if (req_ready !== 1'b1 || req_ready2 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b%b required 11", req_ready, req_ready2);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if ({cs, miso, busy, frame_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_hold: cs/miso/busy/done=%b required 0000",
               {cs, miso, busy, frame_done});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [63:0] f;
    n_tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_before: ready=%b busy=%b required 1 0", req_ready, busy);
    end
    req_cmd   = 8'hFF;
    req_addr  = 24'hABCDEF;
    req_data  = 32'h12345678;
    req_valid = 1'b1;
    capture(70, 1'b0);
    f = frame_at(0);
    n_tests++;
    if (f !== 64'hFFABCDEF12345678) begin
      n_fail++;
      $display("FAIL single_frame: got %h required ffabcdef12345678", f);
    end
    n_tests++;
    if (f[7:0] !== 8'b0111_1000) begin
      n_fail++;
      $display("FAIL single_first8: bits7..0=%b required 01111000", f[7:0]);
    end
    n_tests++;
    if (cs_run(0, 1'b1) != CsLenDef) begin
      n_fail++;
      $display("FAIL single_cs_len: got %0d required %0d", cs_run(0, 1'b1), CsLenDef);
    end
    n_tests++;
    if (miso_s[64] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_miso_tail: got %b required 0", miso_s[64]);
    end
    n_tests++;
    if (fd_count() != 1 || fd_first() != FdIdxDef) begin
      n_fail++;
      $display("FAIL single_done: count %0d at %0d required 1 at %0d",
               fd_count(), fd_first(), FdIdxDef);
    end
    n_tests++;
    if (first_ready(0) != RdyIdxDef) begin
      n_fail++;
      $display("FAIL single_ready: first ready %0d required %0d", first_ready(0), RdyIdxDef);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  c1;
    logic [23:0] a1;
    logic [31:0] d1;
    c1 = 8'($urandom);
    a1 = 24'($urandom);
    d1 = $urandom;
    req_cmd   = c1;
    req_addr  = a1;
    req_data  = d1;
    req_valid = 1'b1;
    clear_samples();
    sample_one(1'b0);
    req_cmd  = 8'hFF;
    req_addr = 24'h000001;
    req_data = 32'hFFFFFFFF;
    for (int i = 1; i < 137; i++) begin
      sample_one(1'b0);
      if (i == 67) req_valid = 1'b0;
    end
    n_tests++;
    if (frame_at(0) !== {c1, a1, d1}) begin
      n_fail++;
      $display("FAIL b2b_frame1: got %h required %h", frame_at(0), {c1, a1, d1});
    end
    n_tests++;
    if (cs_run(0, 1'b1) != CsLenDef || cs_run(CsLenDef, 1'b0) != 2) begin
      n_fail++;
      $display("FAIL b2b_gap: cs high %0d low %0d required %0d and 2",
               cs_run(0, 1'b1), cs_run(CsLenDef, 1'b0), CsLenDef);
    end
    n_tests++;
    if (cs_s[67] !== 1'b1 || first_ready(0) != RdyIdxDef) begin
      n_fail++;
      $display("FAIL b2b_accept: cs@67=%b first ready %0d required 1 and %0d",
               cs_s[67], first_ready(0), RdyIdxDef);
    end
    n_tests++;
    if (frame_at(67) !== 64'hFF000001FFFFFFFF) begin
      n_fail++;
      $display("FAIL b2b_frame2: got %h required ff000001ffffffff", frame_at(67));
    end
    n_tests++;
    if (cs_run(67, 1'b1) != CsLenDef || fd_count() != 2) begin
      n_fail++;
      $display("FAIL b2b_second: cs high %0d done %0d required %0d and 2",
               cs_run(67, 1'b1), fd_count(), CsLenDef);
    end
  endtask

  task automatic test_input_change();
    logic [7:0]  c;
    logic [23:0] a;
    c = 8'($urandom);
    a = 24'($urandom);
    req_cmd   = c;
    req_addr  = a;
    req_data  = 32'hA5A5A5A5;
    req_valid = 1'b1;
    clear_samples();
    for (int i = 0; i < 70; i++) begin
      sample_one(1'b0);
      if (i == 0) req_valid = 1'b0;
      if (i == 9) req_data = 32'h0;
    end
    n_tests++;
    if (frame_at(0) !== {c, a, 32'hA5A5A5A5}) begin
      n_fail++;
      $display("FAIL change_frame: got %h required %h", frame_at(0), {c, a, 32'hA5A5A5A5});
    end
    n_tests++;
    if (first_ready(0) != RdyIdxDef || busy_run(0) != RdyIdxDef) begin
      n_fail++;
      $display("FAIL change_busy: first ready %0d busy run %0d required %0d",
               first_ready(0), busy_run(0), RdyIdxDef);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] f;
    logic        saw_done;
    f = {8'($urandom), 24'($urandom), 32'($urandom)};
    {req_cmd, req_addr, req_data} = f;
    req_valid = 1'b1;
    capture(21, 1'b0);
    n_tests++;
    if (miso_s[20] !== f[20] || cs_s[20] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_bit20: miso=%b cs=%b required %b 1", miso_s[20], cs_s[20], f[20]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({cs, miso, busy, frame_done} !== 4'b0000 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_abort: cs/miso/busy/done/ready=%b required 00001",
               {cs, miso, busy, frame_done, req_ready});
    end
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (frame_done !== 1'b0) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    n_tests++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_done: frame_done seen=%b required 0", saw_done);
    end
    @(negedge clk);
    f = {8'($urandom), 24'($urandom), 32'($urandom)};
    {req_cmd, req_addr, req_data} = f;
    req_valid = 1'b1;
    capture(70, 1'b0);
    n_tests++;
    if (frame_at(0) !== f || cs_run(0, 1'b1) != CsLenDef || fd_count() != 1) begin
      n_fail++;
      $display("FAIL mid_next: got %h cs %0d done %0d required %h %0d 1",
               frame_at(0), cs_run(0, 1'b1), fd_count(), f, CsLenDef);
    end
  endtask

  task automatic test_tail3_gap0();
    logic [63:0] f;
    @(negedge clk);
    f = {8'($urandom), 24'($urandom), 32'($urandom)};
    {req_cmd, req_addr, req_data} = f;
    req_valid2 = 1'b1;
    capture(80, 1'b1);
    n_tests++;
    if (frame_at(0) !== f) begin
      n_fail++;
      $display("FAIL t3_frame: got %h required %h", frame_at(0), f);
    end
    n_tests++;
    if (cs_run(0, 1'b1) != CsLenT3) begin
      n_fail++;
      $display("FAIL t3_cs_len: got %0d required %0d", cs_run(0, 1'b1), CsLenT3);
    end
    n_tests++;
    if (fd_count() != 1 || fd_first() != FdIdxT3 || first_ready(0) != RdyIdxT3) begin
      n_fail++;
      $display("FAIL t3_done_ready: done %0d at %0d ready %0d required 1 at %0d ready %0d",
               fd_count(), fd_first(), first_ready(0), FdIdxT3, RdyIdxT3);
    end
  endtask

  task automatic test_random();
    logic [63:0] f;
    int          scramble_at;
    for (int n = 0; n < 5; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      f = {8'($urandom), 24'($urandom), 32'($urandom)};
      {req_cmd, req_addr, req_data} = f;
      req_valid   = 1'b1;
      scramble_at = int'($urandom_range(1, 60));
      clear_samples();
      for (int i = 0; i < 70; i++) begin
        sample_one(1'b0);
        if (i == 0) req_valid = 1'b0;
        if (i == scramble_at) {req_cmd, req_addr, req_data} = {$urandom, $urandom};
      end
      n_tests++;
      if (frame_at(0) !== f) begin
        n_fail++;
        $display("FAIL rand_frame[%0d]: got %h required %h", n, frame_at(0), f);
      end
      n_tests++;
      if (cs_run(0, 1'b1) != CsLenDef || fd_first() != FdIdxDef || fd_count() != 1) begin
        n_fail++;
        $display("FAIL rand_timing[%0d]: cs %0d done at %0d x%0d required %0d at %0d x1",
                 n, cs_run(0, 1'b1), fd_first(), fd_count(), CsLenDef, FdIdxDef);
      end
    end
  endtask

`ifdef SPI_FRAME_TX_FRAME_CNT_EN
  task automatic test_frame_cnt();
    logic [15:0] want [2];
    want[0] = 16'hFFFF;
    want[1] = 16'h0000;
    @(negedge clk);
    force dut.frame_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.frame_cnt;
    for (int n = 0; n < 2; n++) begin
      {req_cmd, req_addr, req_data} = {$urandom, $urandom};
      req_valid = 1'b1;
      capture(70, 1'b0);
      n_tests++;
      if (frame_cnt !== want[n]) begin
        n_fail++;
        $display("FAIL frame_cnt[%0d]: got %h required %h", n, frame_cnt, want[n]);
      end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_input_change();
    test_reset_mid();
    test_tail3_gap0();
    test_random();
`ifdef SPI_FRAME_TX_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
